// File: rtl/inc_gen_pkg.sv
// Shared definitions for the push-button increment pulse generator:
// FSM state encodings, default timing constants and a small helper.
package inc_gen_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  localparam int DEF_DEBOUNCE_CYCLES = 16;
  localparam int DEF_HOLD_CYCLES     = 50;
  localparam int DEF_REPEAT_CYCLES   = 10;

  // Larger of two integers, used to size the auto-repeat counter.
  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for asynchronous board inputs.
// Both flops reset to 0 asynchronously.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  // Two back-to-back flops give the first one a full cycle to resolve.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/inc_pulse_gen.sv
// Push-button to increment-pulse converter: synchronizes a raw bouncy
// button, debounces press and release, and emits one registered
// single-cycle inc_out pulse per accepted press.
// Optional feature macro AUTO_REPEAT_EN: while the press is held, extra
// pulses follow after HOLD_CYCLES and then every REPEAT_CYCLES.
module inc_pulse_gen
  import inc_gen_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int HOLD_CYCLES     = DEF_HOLD_CYCLES,
  parameter int REPEAT_CYCLES   = DEF_REPEAT_CYCLES
) (
  input  logic clk,
  input  logic resetn,
  input  logic btn_in,
  output logic inc_out,
  output logic btn_level
);

  localparam int                CNT_W    = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  // Reject parameter values the timing logic cannot honour.
  if (DEBOUNCE_CYCLES < 2 || REPEAT_CYCLES < 2 || HOLD_CYCLES < 1) begin : g_param_check
    $error("inc_pulse_gen: DEBOUNCE_CYCLES and REPEAT_CYCLES must be >= 2, HOLD_CYCLES >= 1");
  end

  logic             btn_sync;
  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             press_pulse;
  logic             inc_nxt;
  logic             level_nxt;

  sync_2ff #(.WIDTH(1)) u_sync (
    .clk    (clk),
    .resetn (resetn),
    .d      (btn_in),
    .q      (btn_sync)
  );

  // Debounce FSM: a WAIT state must see DEBOUNCE_CYCLES more agreeing
  // samples before committing; any reversal abandons the attempt.
  always_comb begin
    state_nxt   = state;
    cnt_nxt     = cnt;
    press_pulse = 1'b0;
    case (state)
      IDLE: begin
        if (btn_sync) state_nxt = PRESS_WAIT;
      end
      PRESS_WAIT: begin
        if (!btn_sync) begin
          state_nxt = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_nxt   = PRESSED;
          press_pulse = 1'b1;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      PRESSED: begin
        if (!btn_sync) state_nxt = RELEASE_WAIT;
      end
      RELEASE_WAIT: begin
        if (btn_sync) begin
          state_nxt = PRESSED;
        end else if (cnt == CNT_LAST) begin
          state_nxt = IDLE;
        end else begin
          cnt_nxt = cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
    // Every state change starts the next debounce window from zero.
    if (state_nxt != state) cnt_nxt = '0;
    level_nxt = (state_nxt == PRESSED) || (state_nxt == RELEASE_WAIT);
  end

`ifdef AUTO_REPEAT_EN
  localparam int                REP_W     = $clog2(max2(HOLD_CYCLES, REPEAT_CYCLES));
  localparam logic [REP_W-1:0]  HOLD_LAST = REP_W'(HOLD_CYCLES - 1);
  localparam logic [REP_W-1:0]  REP_LAST  = REP_W'(REPEAT_CYCLES - 1);

  logic [REP_W-1:0] rep, rep_nxt;
  logic             rep_phase, rep_phase_nxt;
  logic             rep_fire;

  // Auto-repeat timer: counts only while staying in PRESSED; first waits
  // out the hold period, then fires at the repeat period. Any entry to or
  // exit from PRESSED restarts it in the hold phase.
  always_comb begin
    rep_nxt       = '0;
    rep_phase_nxt = 1'b0;
    rep_fire      = 1'b0;
    if (state == PRESSED && state_nxt == PRESSED) begin
      rep_phase_nxt = rep_phase;
      rep_nxt       = rep + 1'b1;
      if (rep == (rep_phase ? REP_LAST : HOLD_LAST)) begin
        rep_fire      = 1'b1;
        rep_nxt       = '0;
        rep_phase_nxt = 1'b1;
      end
    end
    inc_nxt = press_pulse | rep_fire;
  end

  // Auto-repeat timer registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      rep       <= '0;
      rep_phase <= 1'b0;
    end else begin
      rep       <= rep_nxt;
      rep_phase <= rep_phase_nxt;
    end
  end
`else
  assign inc_nxt = press_pulse;
`endif

  // State, debounce counter and registered outputs update together.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state     <= IDLE;
      cnt       <= '0;
      inc_out   <= 1'b0;
      btn_level <= 1'b0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      inc_out   <= inc_nxt;
      btn_level <= level_nxt;
    end
  end

endmodule

// File: tb/tb_inc_pulse_gen.sv
// Self-checking bench for inc_pulse_gen. A run-length reference model
// (samples delayed by two edges; the debounced level flips once D+1
// consecutive samples disagree with it) predicts inc_out and btn_level
// every cycle, alongside directed checks and pulse counts.
module tb_inc_pulse_gen;

  localparam int D = 4;
  localparam int H = 8;
  localparam int R = 4;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  logic btn_in = 1'b1;
  logic inc_out;
  logic btn_level;

  int checks = 0;
  int errors = 0;
  int pulses = 0;

  inc_pulse_gen #(
    .DEBOUNCE_CYCLES (D),
    .HOLD_CYCLES     (H),
    .REPEAT_CYCLES   (R)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .btn_in    (btn_in),
    .inc_out   (inc_out),
    .btn_level (btn_level)
  );

  always #1 clk = ~clk;

  // Reference model state.
  bit m_d1 = 0, m_d2 = 0, m_level = 0, m_inc = 0, m_samp = 0;
  int m_run = 0;
  int m_hold = 0;

  always @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      m_d1 = 0; m_d2 = 0; m_level = 0; m_inc = 0; m_run = 0; m_hold = 0;
    end else begin
      m_samp = m_d2;
      m_d2   = m_d1;
      m_d1   = btn_in;
      m_inc  = 0;
      if (m_samp != m_level) begin
        m_run++;
        m_hold = 0;
        if (m_run == D + 1) begin
          m_level = m_samp;
          m_run   = 0;
          if (m_samp) m_inc = 1;
        end
      end else begin
        if (m_level && m_run == 0) begin
          m_hold++;
`ifdef AUTO_REPEAT_EN
          if (m_hold == H || (m_hold > H && (m_hold - H) % R == 0)) m_inc = 1;
`endif
        end else begin
          m_hold = 0;
        end
        m_run = 0;
      end
    end
  end

  task automatic chk(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance one clock, then compare both outputs with the model.
  task automatic cycle();
    @(negedge clk);
    chk("inc_out_model", inc_out, m_inc);
    chk("btn_level_model", btn_level, m_level);
    if (inc_out === 1'b1) pulses++;
  endtask

  task automatic hold(input logic v, input int n);
    btn_in = v;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int p0;
    int exp_cnt;
    logic [7:0] pattern;

    // Reset held with the button pressed: outputs stay low.
    btn_in = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("reset_inc", inc_out, 1'b0);
      chk("reset_level", btn_level, 1'b0);
    end
    resetn = 1'b1;  // released at 10 ns
    for (int e = 1; e <= 8; e++) begin
      cycle();
      chk("rst_release_inc", inc_out, (e == 7) ? 1'b1 : 1'b0);
      chk("rst_release_level", btn_level, (e >= 7) ? 1'b1 : 1'b0);
    end

    // Release, then clean press held 20 cycles.
    hold(1'b0, 12);
    chk("released_level", btn_level, 1'b0);
    p0 = pulses;
    btn_in = 1'b1;
    for (int e = 1; e <= 20; e++) begin
      cycle();
      if (e <= 8) begin
        chk("press_inc", inc_out, (e == 7) ? 1'b1 : 1'b0);
        chk("press_level", btn_level, (e >= 7) ? 1'b1 : 1'b0);
      end
    end
`ifdef AUTO_REPEAT_EN
    exp_cnt = 3;
`else
    exp_cnt = 1;
`endif
    chk_int("clean_press_count", pulses - p0, exp_cnt);

    // Bounce train then stable high.
    hold(1'b0, 12);
    pattern = 8'b1101_1101;  // sent MSB first: 1,1,0,1,1,1,0,1
    p0 = pulses;
    for (int i = 7; i >= 0; i--) hold(pattern[i], 1);
    chk_int("bounce_no_pulse", pulses - p0, 0);
    p0 = pulses;
    hold(1'b1, 10);
    chk_int("bounce_then_stable", pulses - p0, 1);
    chk("bounce_level", btn_level, 1'b1);

    // Short release glitch while pressed: level holds, no pulse.
    p0 = pulses;
    btn_in = 1'b0;
    for (int i = 0; i < 2; i++) begin cycle(); chk("glitch_level", btn_level, 1'b1); end
    btn_in = 1'b1;
    for (int i = 0; i < 6; i++) begin cycle(); chk("glitch_level", btn_level, 1'b1); end
    chk_int("glitch_no_pulse", pulses - p0, 0);
    btn_in = 1'b0;
    for (int e = 1; e <= 10; e++) begin
      cycle();
      chk("release_level", btn_level, (e >= 7) ? 1'b0 : 1'b1);
      chk("release_inc", inc_out, 1'b0);
    end

    // Two separate presses.
    p0 = pulses;
    hold(1'b1, 10);
    hold(1'b0, 10);
    hold(1'b1, 10);
    chk_int("two_presses", pulses - p0, 2);

    // Long hold.
    hold(1'b0, 12);
    p0 = pulses;
    hold(1'b1, 32);
`ifdef AUTO_REPEAT_EN
    exp_cnt = 6;
`else
    exp_cnt = 1;
`endif
    chk_int("long_hold_count", pulses - p0, exp_cnt);
    hold(1'b0, 12);

    // Randomized segments with occasional mid-run resets.
    for (int s = 0; s < 250; s++) begin
      if ($urandom_range(0, 40) == 0) begin
        resetn = 1'b0;
        #0;
        for (int i = 0; i < 2; i++) begin
          cycle();
          chk("rand_reset_inc", inc_out, 1'b0);
          chk("rand_reset_level", btn_level, 1'b0);
        end
        resetn = 1'b1;
      end
      if ($urandom_range(0, 2) == 0)
        hold(1'($urandom_range(0, 1)), $urandom_range(1, 3));
      else
        hold(1'($urandom_range(0, 1)), $urandom_range(4, 14));
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
